br_credit_return: RTL and testbench

- Receiver-side endpoint of the credit flow-control link; the sender side tracks its credit pool with a credit counter.
- Tracks how many receive-buffer slots are occupied by flits from the sender.
- Accumulates credits freed as downstream logic pops the buffer, and returns them to the sender as a registered per-cycle credit count.
- After reset, releases an initial credit grant before normal operation.
- No data flows through this block.

---
 rtl/br_credit_return.sv | 138 +++++++++++++
 tb/tb_br_credit_return.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/br_credit_return.sv
// br_credit_return: receiver-side endpoint of the credit link.
// Tracks buffer occupancy and returns freed slots as credits.
module br_credit_return #(
  parameter int NumCredits = 8,
  parameter int MaxReturn  = 1,
  localparam int CountWidth  = $clog2(NumCredits + 1),
  localparam int ReturnWidth = $clog2(MaxReturn + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [CountWidth-1:0]  initial_credits,
  input  logic                   push_valid,
  input  logic                   pop,
  input  logic                   credit_stall,
  output logic [ReturnWidth-1:0] push_credit,
  output logic [CountWidth-1:0]  pending,
  output logic [CountWidth-1:0]  occupancy,
  output logic                   init_done,
  output logic                   overflow_err,
  output logic                   underflow_err
);

  localparam int AW = CountWidth + 1;
  localparam logic [AW-1:0] MaxRetA = AW'(MaxReturn);
  localparam logic [AW-1:0] NumA    = AW'(NumCredits);
  localparam logic [CountWidth-1:0] NumC = CountWidth'(NumCredits);

  typedef enum logic {
    INIT,
    RUN
  } state_e;

  state_e                 state_q, state_d;
  logic [CountWidth-1:0]  pending_q, pending_d;
  logic [CountWidth-1:0]  occ_q, occ_d;
  logic [ReturnWidth-1:0] pc_q, pc_d;
  logic                   ovf_q, ovf_d;
  logic                   unf_q, unf_d;

  logic                  pop_eff;
  logic [AW-1:0]         avail;
  logic [AW-1:0]         ret;
  logic [AW-1:0]         rem;
  logic [CountWidth-1:0] occ_after;
  logic [CountWidth-1:0] init_clamp;

  // Return arithmetic: freed slots plus owed credits, capped per cycle.
  assign pop_eff    = pop && (occ_q != '0);
  assign avail      = {1'b0, pending_q} + AW'(pop_eff);
  assign ret        = credit_stall ? '0 :
                      ((avail > MaxRetA) ? MaxRetA : avail);
  assign rem        = avail - ret;
  assign occ_after  = occ_q - CountWidth'(pop_eff);
  assign init_clamp = (initial_credits > NumC) ? NumC : initial_credits;

  // Next-state and output computation for the INIT/RUN machine.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    occ_d     = occ_q;
    pc_d      = '0;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    unique case (state_q)
      INIT: begin
        pending_d = init_clamp;
        state_d   = RUN;
      end
      RUN: begin
        pc_d = ReturnWidth'(ret);
        if (rem > NumA) begin
          pending_d = NumC;
          ovf_d     = 1'b1;
        end else begin
          pending_d = rem[CountWidth-1:0];
        end
        if (pop && (occ_q == '0)) begin
          unf_d = 1'b1;
        end
        occ_d = occ_after;
        if (push_valid) begin
          if (occ_after == NumC) begin
            ovf_d = 1'b1;
          end else begin
            occ_d = occ_after + 1'b1;
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= INIT;
      pending_q <= '0;
      occ_q     <= '0;
      pc_q      <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      occ_q     <= occ_d;
      pc_q      <= pc_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  assign push_credit   = pc_q;
  assign pending       = pending_q;
  assign occupancy     = occ_q;
  assign init_done     = (state_q == RUN);
  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;

  // Integration checks; the local conservation check is meaningless
  // once a protocol error has been flagged.
  a_init_range: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == INIT) |-> (initial_credits <= NumC));
  a_no_x: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == RUN) |-> !$isunknown({push_valid, pop}));
  a_conserve: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == RUN && !ovf_q && !unf_q) |->
      ({1'b0, occ_q} + {1'b0, pending_q} <= NumA));

  c_max_ret: cover property (@(posedge clk) disable iff (!rst_n)
    push_credit == ReturnWidth'(MaxReturn));
  c_stall: cover property (@(posedge clk) disable iff (!rst_n)
    credit_stall && (pending_q != '0));
  c_full: cover property (@(posedge clk) disable iff (!rst_n)
    occ_q == NumC);
  c_both: cover property (@(posedge clk) disable iff (!rst_n)
    push_valid && pop);

endmodule

// File: tb/tb_br_credit_return.sv
// tb_br_credit_return: directed bench for br_credit_return.
// NumCredits=8, MaxReturn=2; expected values hand-computed.
module tb_br_credit_return;

  localparam int N  = 8;
  localparam int MR = 2;
  localparam int CW = $clog2(N + 1);
  localparam int RW = $clog2(MR + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] initial_credits = '0;
  logic          push_valid = 1'b0;
  logic          pop = 1'b0;
  logic          credit_stall = 1'b0;
  logic [RW-1:0] push_credit;
  logic [CW-1:0] pending;
  logic [CW-1:0] occupancy;
  logic          init_done;
  logic          overflow_err;
  logic          underflow_err;

  int n_chk  = 0;
  int n_pass = 0;

  br_credit_return #(
    .NumCredits(N),
    .MaxReturn (MR)
  ) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .initial_credits(initial_credits),
    .push_valid     (push_valid),
    .pop            (pop),
    .credit_stall   (credit_stall),
    .push_credit    (push_credit),
    .pending        (pending),
    .occupancy      (occupancy),
    .init_done      (init_done),
    .overflow_err   (overflow_err),
    .underflow_err  (underflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input int n);
    for (int i = 0; i < n; i++) begin
      push_valid = 1'b1;
      cyc();
    end
    push_valid = 1'b0;
  endtask

  initial begin
    // 1: reset, then initial grant of 8 at 2 per cycle
    initial_credits = CW'(8);
    rst_n = 1'b0;
    cyc();
    cyc();
    chk("rst_pc", push_credit, 0);
    chk("rst_pend", pending, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_done", init_done, 0);
    chk("rst_ovf", overflow_err, 0);
    chk("rst_unf", underflow_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t1_done_pre", init_done, 0);
    cyc();
    chk("t1_c1_pc", push_credit, 0);
    chk("t1_c1_pend", pending, 8);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t1_pc", push_credit, 2);
      chk("t1_pend", pending, 6 - 2 * i);
    end
    chk("t1_done", init_done, 1);
    cyc();
    chk("t1_pc_end", push_credit, 0);
    chk("t1_pend_end", pending, 0);

    // 2: three pushes then three consecutive pops
    push_n(3);
    chk("t2_occ3", occupancy, 3);
    pop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t2_pc", push_credit, 1);
      chk("t2_pend", pending, 0);
      chk("t2_occ", occupancy, 2 - i);
    end
    pop = 1'b0;
    cyc();
    chk("t2_pc_end", push_credit, 0);

    // 3: stall four cycles with three pops, then release
    push_n(3);
    credit_stall = 1'b1;
    pop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t3_pc_stall", push_credit, 0);
      chk("t3_pend", pending, i + 1);
      chk("t3_occ", occupancy, 2 - i);
    end
    pop = 1'b0;
    cyc();
    chk("t3_pc_stall4", push_credit, 0);
    chk("t3_pend4", pending, 3);
    credit_stall = 1'b0;
    cyc();
    chk("t3_rel_pc2", push_credit, 2);
    chk("t3_rel_pend1", pending, 1);
    cyc();
    chk("t3_rel_pc1", push_credit, 1);
    chk("t3_rel_pend0", pending, 0);
    cyc();
    chk("t3_rel_pc0", push_credit, 0);

    // 5: mid-run async reset with pending=5, occupancy=3
    push_n(8);
    chk("t5_occ8", occupancy, 8);
    credit_stall = 1'b1;
    pop = 1'b1;
    repeat (5) cyc();
    chk("t5_pend5", pending, 5);
    chk("t5_occ3", occupancy, 3);
    #2;
    rst_n = 1'b0;
    pop = 1'b0;
    credit_stall = 1'b0;
    initial_credits = CW'(3);
    #1;
    chk("t5_async_pend", pending, 0);
    chk("t5_async_occ", occupancy, 0);
    chk("t5_async_done", init_done, 0);
    chk("t5_async_pc", push_credit, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk("t5_c1_pc", push_credit, 0);
    chk("t5_c1_pend", pending, 3);
    cyc();
    chk("t5_c2_pc", push_credit, 2);
    chk("t5_c2_pend", pending, 1);
    cyc();
    chk("t5_c3_pc", push_credit, 1);
    chk("t5_c3_pend", pending, 0);
    cyc();
    chk("t5_c4_pc", push_credit, 0);

    // 4: overflow at full, legal push+pop at full, underflow
    push_n(8);
    chk("t4_occ8", occupancy, 8);
    chk("t4_ovf_pre", overflow_err, 0);
    push_valid = 1'b1;
    cyc();
    chk("t4_ovf", overflow_err, 1);
    chk("t4_ovf_occ", occupancy, 8);
    chk("t4_ovf_unf", underflow_err, 0);
    pop = 1'b1;
    cyc();
    chk("t4_both_occ", occupancy, 8);
    chk("t4_both_pc", push_credit, 1);
    chk("t4_both_unf", underflow_err, 0);
    push_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("t4_drain_pc", push_credit, 1);
      chk("t4_drain_occ", occupancy, 7 - i);
    end
    chk("t4_unf_pre", underflow_err, 0);
    cyc();
    pop = 1'b0;
    chk("t4_unf", underflow_err, 1);
    chk("t4_unf_pc", push_credit, 0);
    chk("t4_unf_pend", pending, 0);
    chk("t4_unf_occ", occupancy, 0);
    cyc();
    chk("t4_sticky_ovf", overflow_err, 1);
    chk("t4_sticky_unf", underflow_err, 1);

    // 6: zero initial credits, one flit pushed then popped
    rst_n = 1'b0;
    initial_credits = CW'(0);
    cyc();
    chk("t6_rst_ovf", overflow_err, 0);
    chk("t6_rst_unf", underflow_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk("t6_c1_pend", pending, 0);
    cyc();
    chk("t6_c2_pc", push_credit, 0);
    push_n(1);
    chk("t6_occ1", occupancy, 1);
    chk("t6_pc_push", push_credit, 0);
    pop = 1'b1;
    cyc();
    pop = 1'b0;
    chk("t6_pc_pop", push_credit, 1);
    chk("t6_pend", pending, 0);
    chk("t6_occ0", occupancy, 0);
    cyc();
    chk("t6_pc_end", push_credit, 0);
    chk("t6_unf", underflow_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
